tx_serializer: RTL and testbench

Serial transmit stage downstream of the access controller's read/write flow. It captures a parallel word from memory when the controller pulses `PARALLEL_LOAD` and, on `Tx_DATA`, shifts it out as a framed serial stream. When the frame completes it returns `Tx_DONE` to the controller, which closes the controller's read/transmit handshake.

---
 rtl/tx_serializer_if.sv | 21 ++
 rtl/tx_serializer.sv | 142 ++++++++++++++
 tb/tb_tx_serializer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_serializer_if.sv
// Parallel-load / transmit handshake between the access controller and tx_serializer.
interface tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DIN;
    logic                  PARALLEL_LOAD;
    logic                  Tx_DATA;
    logic                  TX_OUT;
    logic                  BUSY;
    logic                  Tx_DONE;

    modport master (
        output DIN, PARALLEL_LOAD, Tx_DATA,
        input  TX_OUT, BUSY, Tx_DONE
    );

    modport slave (
        input  DIN, PARALLEL_LOAD, Tx_DATA,
        output TX_OUT, BUSY, Tx_DONE
    );
endinterface

// File: rtl/tx_serializer.sv
// Framed LSB-first serial transmitter: start bit, payload, optional even parity, stop bit.
// Optional feature: define TX_PARITY_EN to insert an even-parity bit between data and stop.
module tx_serializer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    tx_serializer_if.slave  bus
);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_W-1:0]      bit_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  tx_out;
    logic                  busy;
    logic                  done;
`ifdef TX_PARITY_EN
    logic                  parity;
`endif

    logic [DATA_WIDTH-1:0] start_word;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  last_tick;

    // A load in the same cycle as a start goes straight into the frame
    assign start_word = bus.PARALLEL_LOAD ? bus.DIN : hold;
    assign shift_nxt  = shift >> 1;
    assign last_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            hold    <= '0;
            shift   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    if (bus.PARALLEL_LOAD) hold <= bus.DIN;
                    if (bus.Tx_DATA) begin
                        shift  <= start_word;
                        state  <= START;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= '0;
`ifdef TX_PARITY_EN
                        parity <= ^start_word;
`endif
                    end
                end
                START: begin
                    if (last_tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_out  <= shift[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        cnt   <= '0;
                        shift <= shift_nxt;
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= parity;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            tx_out  <= shift_nxt[0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        cnt    <= '0;
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        cnt    <= '0;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        tx_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_OUT  = tx_out;
    assign bus.BUSY    = busy;
    assign bus.Tx_DONE = done;
endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: expected per-cycle line states queued at frame start, monitors pop on BUSY/Tx_DONE.
module tb_tx_serializer;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // {TX_OUT, BUSY, Tx_DONE} expected for each active cycle
    logic [2:0] q1[$];
    logic [2:0] q4[$];

`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    tx_serializer_if #(.DATA_WIDTH(8)) bus1 ();
    tx_serializer_if #(.DATA_WIDTH(8)) bus4 ();

    tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus1.slave)
    );
    tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .bus(bus4.slave)
    );

    always #5 CLK = ~CLK;

    // Expected line: start 0, payload LSB first, [parity], stop 1, then one Tx_DONE cycle
    function automatic void push_frame(input logic [7:0] w, input bit slow);
        int   cpb;
        logic bits [FRAME_BITS];
        cpb = slow ? 4 : 1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = w[i];
`ifdef TX_PARITY_EN
        bits[9] = ^w;
`endif
        bits[FRAME_BITS-1] = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++)
            for (int c = 0; c < cpb; c++)
                if (slow) q4.push_back({bits[b], 1'b1, 1'b0});
                else      q1.push_back({bits[b], 1'b1, 1'b0});
        if (slow) q4.push_back(3'b101);
        else      q1.push_back(3'b101);
    endfunction

    always @(negedge CLK) begin
        if (!RESET) begin
            logic [2:0] act;
            logic [2:0] exp;
            act = {bus1.TX_OUT, bus1.BUSY, bus1.Tx_DONE};
            checks++;
            if (bus1.BUSY || bus1.Tx_DONE) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected got=%b (tx,busy,done) expected idle", act);
                end else begin
                    exp = q1.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL dut1_line t=%0t got=%b expected=%b", $time, act, exp);
                    end
                end
            end else if (act !== 3'b100 || q1.size() != 0) begin
                errors++;
                $display("FAIL dut1_idle t=%0t got=%b expected=100 pending=%0d", $time, act, q1.size());
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            logic [2:0] act;
            logic [2:0] exp;
            act = {bus4.TX_OUT, bus4.BUSY, bus4.Tx_DONE};
            checks++;
            if (bus4.BUSY || bus4.Tx_DONE) begin
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL dut4_unexpected got=%b expected idle", act);
                end else begin
                    exp = q4.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL dut4_line t=%0t got=%b expected=%b", $time, act, exp);
                    end
                end
            end else if (act !== 3'b100 || q4.size() != 0) begin
                errors++;
                $display("FAIL dut4_idle t=%0t got=%b expected=100 pending=%0d", $time, act, q4.size());
            end
        end
    end

    task automatic check_out(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    // Called at posedge+1; pulses a start (optionally with a load) for dut1
    task automatic start_frame(input logic ld, input logic [7:0] d, input logic [7:0] w);
        bus1.DIN = d;
        bus1.PARALLEL_LOAD = ld;
        bus1.Tx_DATA = 1'b1;
        @(posedge CLK);
        push_frame(w, 1'b0);
        #1;
        bus1.PARALLEL_LOAD = 1'b0;
        bus1.Tx_DATA = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 400) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending1=%0d pending4=%0d expected 0", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus1.DIN = '0; bus1.PARALLEL_LOAD = 1'b0; bus1.Tx_DATA = 1'b0;
        bus4.DIN = '0; bus4.PARALLEL_LOAD = 1'b0; bus4.Tx_DATA = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_out("reset_dut1", {bus1.TX_OUT, bus1.BUSY, bus1.Tx_DONE}, 3'b100);
        check_out("reset_dut4", {bus4.TX_OUT, bus4.BUSY, bus4.Tx_DONE}, 3'b100);
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Separate load then start
        bus1.DIN = 8'hA5; bus1.PARALLEL_LOAD = 1'b1;
        @(posedge CLK); #1;
        bus1.PARALLEL_LOAD = 1'b0;
        start_frame(1'b0, 8'h00, 8'hA5);
        drain();

        start_frame(1'b1, 8'h07, 8'h07);
        drain();

        // Slow bit period
        bus4.DIN = 8'h01; bus4.PARALLEL_LOAD = 1'b1; bus4.Tx_DATA = 1'b1;
        @(posedge CLK);
        push_frame(8'h01, 1'b1);
        #1;
        bus4.PARALLEL_LOAD = 1'b0; bus4.Tx_DATA = 1'b0;
        drain();

        // Load and start pulses while busy are ignored
        start_frame(1'b1, 8'h3C, 8'h3C);
        repeat (3) @(posedge CLK);
        #1;
        bus1.DIN = 8'hFF; bus1.PARALLEL_LOAD = 1'b1; bus1.Tx_DATA = 1'b1;
        @(posedge CLK); #1;
        bus1.PARALLEL_LOAD = 1'b0; bus1.Tx_DATA = 1'b0;
        drain();
        start_frame(1'b0, 8'hFF, 8'h3C);
        drain();

        // Simultaneous load+start, then Tx_DATA held through Tx_DONE for back-to-back
        bus1.DIN = 8'h5A; bus1.PARALLEL_LOAD = 1'b1; bus1.Tx_DATA = 1'b1;
        @(posedge CLK);
        push_frame(8'h5A, 1'b0);
        #1;
        bus1.PARALLEL_LOAD = 1'b0;
        bus1.DIN = 8'h00;
        repeat (FRAME_BITS) @(posedge CLK);
        @(posedge CLK);
        push_frame(8'h5A, 1'b0);
        #1;
        bus1.Tx_DATA = 1'b0;
        drain();

        // Asynchronous reset during data bit 3
        start_frame(1'b1, 8'hA5, 8'hA5);
        repeat (4) @(posedge CLK);
        #2;
        RESET = 1'b1;
        q1.delete();
        #1;
        check_out("reset_midframe", {bus1.TX_OUT, bus1.BUSY, bus1.Tx_DONE}, 3'b100);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (FRAME_BITS + 3) @(posedge CLK);
        #1;
        start_frame(1'b0, 8'hFF, 8'h00);
        drain();

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
